// File: rtl/n_term_frame_loader.sv
// Configuration frame loader: parses a header word, collects N row words into
// FrameData, then pulses a one-hot FrameStrobe into the column's ConfigMem.
module n_term_frame_loader #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 2,
    parameter int ColumnIndex     = 0
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic [FrameBitsPerRow-1:0]              s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]              FrameStrobe,
    output logic                                    busy,
    output logic                                    err
);
    localparam logic [7:0]                 SyncByte  = 8'hFA;
    localparam logic [7:0]                 RowLimit  = 8'(NumberOfRows);
    localparam logic [7:0]                 MyColumn  = 8'(ColumnIndex);
    localparam logic [31:0]                FrameMax  = 32'(MaxFramesPerCol);
    localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

    typedef enum logic [2:0] {IDLE, DATA, SETUP, STROBE, HOLD} stateT;

    stateT      state;
    logic [7:0] colIdx;
    logic [7:0] frameIdx;
    logic [7:0] rowTotal;
    logic [7:0] rowCnt;

    logic xfer;
    logic hdrOk;
    logic lastRow;
    logic colMatch;
    logic frameInRange;

    assign xfer         = s_valid && s_ready;
    assign hdrOk        = (s_data[31:24] == SyncByte) && (s_data[7:0] != 8'd0) &&
                          (s_data[7:0] <= RowLimit);
    assign lastRow      = (rowCnt + 8'd1) == rowTotal;
    assign colMatch     = colIdx == MyColumn;
    assign frameInRange = {24'd0, frameIdx} < FrameMax;

    // s_ready and busy are registered alongside the state they describe, so
    // they reflect the state being entered and never look at s_valid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            FrameData   <= '0;
            FrameStrobe <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            s_ready     <= 1'b0;
            rowCnt      <= 8'd0;
            rowTotal    <= 8'd0;
            colIdx      <= 8'd0;
            frameIdx    <= 8'd0;
        end else begin
            err         <= 1'b0;
            FrameStrobe <= '0;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    if (xfer) begin
                        if (hdrOk) begin
                            colIdx    <= s_data[23:16];
                            frameIdx  <= s_data[15:8];
                            rowTotal  <= s_data[7:0];
                            rowCnt    <= 8'd0;
                            FrameData <= '0;
                            busy      <= 1'b1;
                            state     <= DATA;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        for (int r = 0; r < NumberOfRows; r++) begin
                            if (rowCnt == 8'(r)) begin
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                            end
                        end
                        rowCnt <= rowCnt + 8'd1;
                        if (lastRow) begin
                            if (colMatch && frameInRange) begin
                                s_ready <= 1'b0;
                                state   <= SETUP;
                            end else begin
                                err   <= colMatch;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                SETUP: begin
                    FrameStrobe <= StrobeOne << frameIdx;
                    state       <= STROBE;
                end
                STROBE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_n_term_frame_loader.sv
// Bench for n_term_frame_loader: directed scenarios plus randomized frames,
// checked every cycle against a transaction-level model of the loader.
module tb_n_term_frame_loader;
    localparam int MF = 20;
    localparam int FB = 32;
    localparam int NR = 2;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [FB-1:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [NR*FB-1:0] FrameData;
    logic [MF-1:0]    FrameStrobe;
    logic             busy;
    logic             err;

    n_term_frame_loader dut (
        .CLK(CLK), .RESET(RESET), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit checkEn = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: tracks the frame as a transaction (idle / collecting rows /
    // counting cycles since the last row) rather than per-state.
    int               mPhase = 0;
    int               mPost = 0;
    int               mRow = 0;
    int               mN = 0;
    int               mCol = 0;
    int               mFrame = 0;
    logic             expReady = 1'b0;
    logic             expBusy = 1'b0;
    logic             expErr = 1'b0;
    logic [MF-1:0]    expStrobe = '0;
    logic [NR*FB-1:0] expData = '0;

    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            mPhase = 0; mPost = 0; mRow = 0;
            expReady = 1'b0; expBusy = 1'b0; expErr = 1'b0;
            expStrobe = '0; expData = '0;
        end else begin
            automatic bit acc = expReady && s_valid;
            automatic int n = int'(s_data[7:0]);
            expErr = 1'b0;
            expStrobe = '0;
            if (mPhase == 0) begin
                expReady = 1'b1;
                if (acc) begin
                    if (s_data[31:24] == 8'hFA && n >= 1 && n <= NR) begin
                        mCol = int'(s_data[23:16]);
                        mFrame = int'(s_data[15:8]);
                        mN = n; mRow = 0; expData = '0;
                        mPhase = 1; expBusy = 1'b1;
                    end else begin
                        expErr = 1'b1;
                    end
                end
            end else if (mPhase == 1) begin
                if (acc) begin
                    expData[mRow*FB +: FB] = s_data;
                    mRow++;
                    if (mRow == mN) begin
                        if (mCol == 0 && mFrame < MF) begin
                            mPhase = 2; mPost = 1; expReady = 1'b0;
                        end else begin
                            mPhase = 0; expBusy = 1'b0;
                            expErr = (mCol == 0);
                        end
                    end
                end
            end else begin
                mPost++;
                if (mPost == 2) expStrobe = MF'(1) << mFrame;
                if (mPost == 4) begin
                    mPhase = 0; expReady = 1'b1; expBusy = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison plus event capture for the directed literal checks.
    int            strobeCount = 0;
    int            strobeCyc = 0;
    logic [MF-1:0] strobeVal = '0;
    int            errCount = 0;
    int            errCyc = 0;
    int            readyRiseCyc = 0;
    logic          prevReady = 1'b0;

    always @(negedge CLK) begin
        if (checkEn) begin
            chk("s_ready", s_ready, expReady);
            chk("busy", busy, expBusy);
            chk("err", err, expErr);
            chk("FrameStrobe", FrameStrobe, expStrobe);
            chk("FrameData", FrameData, expData);
        end
        if (FrameStrobe != '0) begin
            strobeCount++; strobeCyc = cyc; strobeVal = FrameStrobe;
        end
        if (err) begin
            errCount++; errCyc = cyc;
        end
        if (s_ready && !prevReady) readyRiseCyc = cyc;
        prevReady = s_ready;
    end

    int lastAcceptCyc = 0;

    // Presents one word after `gap` idle cycles; returns after it transfers.
    task automatic sendWord(input logic [FB-1:0] w, input int gap);
        int budget;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data = $urandom;
            @(posedge CLK); #1;
        end
        s_valid = 1'b1;
        s_data = w;
        budget = 0;
        while (!s_ready && budget < 30) begin
            @(posedge CLK); #1;
            budget++;
        end
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL sendWord_timeout: s_ready got 0 expected 1 (t=%0t)", $time);
        end else begin
            @(posedge CLK); #1;
            lastAcceptCyc = cyc - 1;
        end
        s_valid = 1'b0;
        s_data = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic clearEvents();
        strobeCount = 0; errCount = 0; strobeVal = '0;
    endtask

    initial begin
        idle(3);
        checkEn = 1'b1;
        chk("reset_ready_low", s_ready, 1'b0);
        chk("reset_data", FrameData, '0);
        RESET = 1'b0;
        idle(1);
        chk("ready_after_release", s_ready, 1'b1);

        // Basic frame to frame index 3.
        clearEvents();
        sendWord(32'hFA00_0302, 0);
        sendWord(32'hDEAD_BEEF, 0);
        sendWord(32'h1234_5678, 0);
        idle(6);
        chk("basic_data", FrameData, {32'h1234_5678, 32'hDEAD_BEEF});
        chk("basic_strobe_val", strobeVal, 20'h00008);
        chk("basic_strobe_count", strobeCount, 1);
        chk("basic_strobe_lat", strobeCyc - lastAcceptCyc, 2);
        chk("basic_ready_lat", readyRiseCyc - lastAcceptCyc, 4);

        // Column mismatch.
        clearEvents();
        sendWord(32'hFA01_0302, 0);
        sendWord(32'hCAFE_0001, 0);
        sendWord(32'hCAFE_0002, 0);
        idle(6);
        chk("col_strobe_count", strobeCount, 0);
        chk("col_err_count", errCount, 0);
        chk("col_data", FrameData, {32'hCAFE_0002, 32'hCAFE_0001});

        // Frame index out of range.
        clearEvents();
        sendWord(32'hFA00_1402, 0);
        sendWord(32'h0000_0011, 0);
        sendWord(32'h0000_0022, 0);
        idle(6);
        chk("range_strobe_count", strobeCount, 0);
        chk("range_err_count", errCount, 1);
        chk("range_err_lat", errCyc - lastAcceptCyc, 1);

        // Bad sync then N=0.
        clearEvents();
        sendWord(32'hAB00_0001, 0);
        sendWord(32'hFA00_0000, 0);
        idle(4);
        chk("badhdr_err_count", errCount, 2);
        chk("badhdr_data", FrameData, {32'h0000_0022, 32'h0000_0011});

        // Single row with valid toggling.
        clearEvents();
        sendWord(32'hFA00_0001, 1);
        sendWord(32'h5A5A_A5A5, 1);
        idle(6);
        chk("toggle_strobe_val", strobeVal, 20'h00001);
        chk("toggle_strobe_count", strobeCount, 1);
        chk("toggle_data", FrameData, {32'h0, 32'h5A5A_A5A5});

        // Reset during the strobe cycle.
        sendWord(32'hFA00_0502, 0);
        sendWord(32'h1111_1111, 0);
        sendWord(32'h2222_2222, 0);
        begin
            int w = 0;
            while (FrameStrobe == '0 && w < 20) begin
                @(negedge CLK); w++;
            end
            chk("strobe_seen", FrameStrobe, 20'h00020);
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("rst_strobe_cleared", FrameStrobe, '0);
        chk("rst_data_cleared", FrameData, '0);
        clearEvents();
        sendWord(32'hFA00_0702, 0);
        sendWord(32'h3333_3333, 0);
        sendWord(32'h4444_4444, 0);
        idle(6);
        chk("post_rst_strobe", strobeVal, 20'h00080);
        chk("post_rst_data", FrameData, {32'h4444_4444, 32'h3333_3333});

        // Randomized frames, good and bad, with random stalls.
        for (int t = 0; t < 250; t++) begin
            logic [7:0] sync, col, frm, n;
            int ok;
            sync = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFA;
            col  = ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0;
            frm  = 8'($urandom_range(0, 24));
            n    = 8'($urandom_range(0, 3));
            ok   = (sync == 8'hFA && n >= 1 && n <= NR) ? 1 : 0;
            sendWord({sync, col, frm, n}, $urandom_range(0, 2));
            if (ok == 1) begin
                for (int r = 0; r < int'(n); r++) sendWord($urandom, $urandom_range(0, 2));
            end
            if ($urandom_range(0, 30) == 0) begin
                RESET = 1'b1;
                idle($urandom_range(1, 2));
                RESET = 1'b0;
            end
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/n_term_frame_loader.md
N_TERM_FRAME_LOADER -- requirements
Module: n_term_frame_loader

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, frames per column; width of FrameStrobe.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, bits per row word; SHALL be >= 32.
REQ-003 SHALL have parameter NumberOfRows, default 2, row words per frame; range 1..255.
REQ-004 SHALL have parameter ColumnIndex, default 0, column address this loader answers to.
REQ-005 SHALL have port CLK, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port s_data, input, FrameBitsPerRow, configuration stream word.
REQ-008 SHALL have port s_valid, input, 1, s_data valid.
REQ-009 SHALL have port s_ready, output, 1, loader accepts word; transfer occurs when s_valid and s_ready are both high.
REQ-010 SHALL have port FrameData, output, NumberOfRows*FrameBitsPerRow, assembled frame; row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
REQ-011 SHALL have port FrameStrobe, output, MaxFramesPerCol, one-hot write strobe to column ConfigMem.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on a protocol error.

Function
REQ-014 SHALL implement states IDLE, DATA, SETUP, STROBE, HOLD.
REQ-015 Header word, low 32 bits: [31:24] sync = 8'hFA; [23:16] column; [15:8] frame index; [7:0] row count N; upper bits ignored.
REQ-016 IDLE, s_ready=1: on a header transfer with valid sync and 1<=N<=NumberOfRows, latch column, frame and N, clear FrameData to 0, reset row counter to 0, go to DATA.
REQ-017 IDLE: bad sync, N=0 or N>NumberOfRows -> word dropped, err pulses the next cycle, stay IDLE.
REQ-018 DATA, s_ready=1: each transfer writes s_data to row[row counter], then increments the counter; rows >= N stay 0.
REQ-019 DATA: the transfer of word N goes to SETUP if the column matches ColumnIndex and frame < MaxFramesPerCol, otherwise to IDLE.
REQ-020 Frame >= MaxFramesPerCol with matching column -> data words consumed, no strobe, err pulses the cycle after the last data word.
REQ-021 Column mismatch -> data words consumed, FrameData still updated, no strobe, no err.
REQ-022 SETUP: one cycle, s_ready=0, FrameData stable, FrameStrobe=0.
REQ-023 STROBE: one cycle, FrameStrobe[frame]=1, all other bits 0, s_ready=0.
REQ-024 HOLD: one cycle, FrameStrobe=0, FrameData unchanged, s_ready=0; then IDLE.
REQ-025 Latency: last data word accepted at edge k -> SETUP in cycle k+1, strobe in cycle k+2, HOLD in cycle k+3, s_ready=1 in cycle k+4.
REQ-026 FrameData SHALL change only on a header accept (clear) or a DATA transfer; it SHALL never change in SETUP, STROBE or HOLD.
REQ-027 s_valid low in DATA SHALL stall without timeout; no state change.
REQ-028 FrameStrobe SHALL be registered, glitch-free, and never have more than one bit set.
REQ-029 s_ready SHALL be a registered function of state only; it SHALL not depend combinationally on s_valid.

Reset
REQ-030 RESET high at an edge -> state IDLE, FrameData=0, FrameStrobe=0, err=0, busy=0, row counter=0.
REQ-031 s_ready SHALL be 0 while RESET is high and 1 in the first cycle after RESET is released.
REQ-032 RESET during any state, including STROBE, SHALL abort immediately; the strobe is deasserted at that edge and the partial frame is discarded.

Verification
REQ-033 Defaults; header 32'hFA00_0302 then 32'hDEAD_BEEF, 32'h1234_5678 -> FrameData = {32'h1234_5678, 32'hDEAD_BEEF}; FrameStrobe = 20'h00008 for exactly one cycle, 2 cycles after the last word; s_ready returns 4 cycles after it.
REQ-034 Header 32'hFA01_0302 (column 1) plus 2 words -> no strobe, no err, s_ready stays 1 throughout.
REQ-035 Header 32'hFA00_1402 (frame 20) plus 2 words -> no strobe; err pulses once, the cycle after the second word.
REQ-036 Header 32'hAB00_0001, then 32'hFA00_0000 -> two err pulses, busy stays 0, FrameData unchanged.
REQ-037 Header 32'hFA00_0001 plus 1 word with s_valid toggling every cycle -> only the valid-high cycles transfer; FrameStrobe = 20'h00001 for one cycle; row 1 = 0.
REQ-038 RESET asserted during the STROBE cycle -> FrameStrobe=0 and FrameData=0 the next cycle; a following valid frame loads normally.
